// File: rtl/dsp38_macc_seq_pkg.sv
// Shared types and constants for the DSP38 multiply-accumulate sequencer.
package dsp38_macc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int A_W     = 20;
  localparam int B_W     = 18;
  localparam int Z_W     = 38;
  localparam int SHIFT_W = 6;

  localparam logic [2:0] FEEDBACK_MULT = 3'b000;

  typedef struct packed {
    logic               unsigned_a;
    logic               unsigned_b;
    logic               subtract;
    logic               saturate;
    logic               round;
    logic [SHIFT_W-1:0] shift;
  } cfg_t;

endpackage

// File: rtl/dsp38_macc_sequencer.sv
// Feeds operand pairs to one DSP38 in accumulate mode, one dot product per vector,
// and returns the captured Z on a valid/ready result port.
module dsp38_macc_sequencer
  import dsp38_macc_seq_pkg::*;
#(
  parameter int INPUT_REG  = 0,
  parameter int OUTPUT_REG = 0,
  parameter int LEN_W      = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [LEN_W-1:0]   CFG_LEN,
  input  logic               CFG_UNSIGNED_A,
  input  logic               CFG_UNSIGNED_B,
  input  logic               CFG_SUBTRACT,
  input  logic               CFG_SATURATE,
  input  logic               CFG_ROUND,
  input  logic [SHIFT_W-1:0] CFG_SHIFT,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [A_W-1:0]     IN_A,
  input  logic [B_W-1:0]     IN_B,
  output logic [A_W-1:0]     DSP_A,
  output logic [B_W-1:0]     DSP_B,
  output logic               DSP_LOAD_ACC,
  output logic [2:0]         DSP_FEEDBACK,
  output logic               DSP_UNSIGNED_A,
  output logic               DSP_UNSIGNED_B,
  output logic               DSP_SUBTRACT,
  output logic               DSP_SATURATE_ENABLE,
  output logic               DSP_ROUND,
  output logic [SHIFT_W-1:0] DSP_SHIFT_RIGHT,
  input  logic [Z_W-1:0]     DSP_Z,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [Z_W-1:0]     OUT_Z,
  output logic               BUSY
);

  // Edges from DSP pins to DSP_Z; both register options are 0 or 1, so 2 bits suffice.
  localparam logic [1:0] PIPE_LAT = 2'(1 + INPUT_REG + OUTPUT_REG);

  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       dcnt_q, dcnt_d;
  cfg_t             cfg_q, cfg_d;
  logic [A_W-1:0]   a_q, a_d;
  logic [B_W-1:0]   b_q, b_d;
  logic             ld_q, ld_d;
  logic [Z_W-1:0]   z_q, z_d;
  logic             vld_q, vld_d;
  logic             rdy_en_q;
  logic             accept;

  // rdy_en_q keeps IN_READY low until the first edge after reset release.
  assign IN_READY = rdy_en_q && (state_q == IDLE || state_q == RUN);
  assign accept   = IN_VALID && IN_READY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    dcnt_d  = dcnt_q;
    cfg_d   = cfg_q;
    a_d     = '0;
    b_d     = '0;
    ld_d    = 1'b0;
    z_d     = z_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          len_d  = eff_len(CFG_LEN);
          cfg_d  = '{unsigned_a: CFG_UNSIGNED_A, unsigned_b: CFG_UNSIGNED_B,
                     subtract: CFG_SUBTRACT, saturate: CFG_SATURATE,
                     round: CFG_ROUND, shift: CFG_SHIFT};
          a_d    = IN_A;
          b_d    = IN_B;
          ld_d   = 1'b1;
          cnt_d  = LEN_W'(1);
          dcnt_d = '0;
          state_d = (eff_len(CFG_LEN) == LEN_W'(1)) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          a_d   = IN_A;
          b_d   = IN_B;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) begin
            dcnt_d  = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (dcnt_q == PIPE_LAT) begin
          z_d     = DSP_Z;
          vld_d   = 1'b1;
          state_d = HOLD;
        end else begin
          dcnt_d = dcnt_q + 2'd1;
        end
      end
      HOLD: begin
        if (OUT_READY) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      dcnt_q   <= '0;
      cfg_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ld_q     <= 1'b0;
      z_q      <= '0;
      vld_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      dcnt_q   <= dcnt_d;
      cfg_q    <= cfg_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ld_q     <= ld_d;
      z_q      <= z_d;
      vld_q    <= vld_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign DSP_A               = a_q;
  assign DSP_B               = b_q;
  assign DSP_LOAD_ACC        = ld_q;
  assign DSP_FEEDBACK        = FEEDBACK_MULT;
  assign DSP_UNSIGNED_A      = cfg_q.unsigned_a;
  assign DSP_UNSIGNED_B      = cfg_q.unsigned_b;
  assign DSP_SUBTRACT        = cfg_q.subtract;
  assign DSP_SATURATE_ENABLE = cfg_q.saturate;
  assign DSP_ROUND           = cfg_q.round;
  assign DSP_SHIFT_RIGHT     = cfg_q.shift;
  assign OUT_VALID           = vld_q;
  assign OUT_Z               = z_q;
  assign BUSY                = (state_q != IDLE);

endmodule
